// File: rtl/maxpool_stream_if.sv
// rtl/maxpool_stream_if.sv - sample-in / pooled-out handshake bundle for maxpool_stream
interface maxpool_stream_if #(
  parameter int WIDTH = 8
);
  logic signed [WIDTH-1:0] s_data_in_y;
  logic                    s_valid_y;
  logic                    s_ready_y;
  logic signed [WIDTH-1:0] m_data_out_p;
  logic                    m_valid_p;
  logic                    m_ready_p;

  // Upstream/downstream side: feeds samples, drains pooled results
  modport master (
    output s_data_in_y, s_valid_y, m_ready_p,
    input  s_ready_y, m_data_out_p, m_valid_p
  );

  // Pooling stage side
  modport slave (
    input  s_data_in_y, s_valid_y, m_ready_p,
    output s_ready_y, m_data_out_p, m_valid_p
  );
endinterface

// File: rtl/maxpool_stream.sv
// rtl/maxpool_stream.sv - streaming 1-D max pooling (average pooling when MAXPOOL_AVG_EN is defined)
module maxpool_stream #(
  parameter int WIDTH = 8,
  parameter int LENY  = 5,
  parameter int LENP  = 2,
  parameter int LOGY  = 3,
  parameter int LOGP  = 1
) (
  input logic clk,
  input logic reset,
  maxpool_stream_if.slave bus
);

`ifdef MAXPOOL_AVG_EN
  localparam int ACCW = WIDTH + LOGP;
`else
  localparam int ACCW = WIDTH;
`endif

  localparam logic [LOGP-1:0] P_LAST = LOGP'(LENP - 1);
  localparam logic [LOGY-1:0] F_LAST = LOGY'(LENY - 1);

  logic [LOGP-1:0]         r_win_cnt;
  logic [LOGY-1:0]         r_frame_cnt;
  logic signed [ACCW-1:0]  r_acc;
  logic signed [WIDTH-1:0] r_data;
  logic                    r_valid;

  logic                    w_win_last;
  logic                    w_in_xfer;
  logic                    w_out_xfer;
  logic signed [ACCW-1:0]  w_sample;
  logic signed [ACCW-1:0]  w_acc_next;
  logic signed [ACCW-1:0]  w_shift;
  logic signed [WIDTH-1:0] w_result;

  // The next accepted sample closes a window: either the window is full or the frame ends
  assign w_win_last = (r_win_cnt == P_LAST) | (r_frame_cnt == F_LAST);

  // A closing sample may only enter when the output register is free or draining this cycle
  assign bus.s_ready_y = ~reset & (~w_win_last | ~r_valid | bus.m_ready_p);

  assign w_in_xfer  = bus.s_valid_y & bus.s_ready_y;
  assign w_out_xfer = r_valid & bus.m_ready_p;

`ifdef MAXPOOL_AVG_EN
  // Sign-extend into the widened sum, add unless this sample opens the window
  assign w_sample   = {{LOGP{bus.s_data_in_y[WIDTH-1]}}, bus.s_data_in_y};
  assign w_acc_next = (r_win_cnt == '0) ? w_sample : (r_acc + w_sample);
  // Floor average; a short tail window behaves as if zero-padded
  assign w_shift    = w_acc_next >>> LOGP;
  assign w_result   = w_shift[WIDTH-1:0];
`else
  // Running signed maximum, restarted by the first sample of each window
  assign w_sample   = bus.s_data_in_y;
  assign w_acc_next = ((r_win_cnt == '0) || (w_sample > r_acc)) ? w_sample : r_acc;
  assign w_shift    = w_acc_next;
  assign w_result   = w_shift;
`endif

  // Window/frame position and accumulator advance on every accepted sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_win_cnt   <= '0;
      r_frame_cnt <= '0;
      r_acc       <= '0;
    end else if (w_in_xfer) begin
      r_acc       <= w_acc_next;
      r_win_cnt   <= w_win_last ? '0 : (r_win_cnt + LOGP'(1));
      r_frame_cnt <= (r_frame_cnt == F_LAST) ? '0 : (r_frame_cnt + LOGY'(1));
    end
  end

  // Result register: a closing sample loads (even while draining), a bare drain clears valid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (w_in_xfer && w_win_last) begin
      r_data  <= w_result;
      r_valid <= 1'b1;
    end else if (w_out_xfer) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.m_data_out_p = r_data;
  assign bus.m_valid_p    = r_valid;

endmodule

// File: tb/tb_maxpool_stream.sv
// tb/tb_maxpool_stream.sv - self-checking bench for maxpool_stream with a queue-based pooling model
module tb_maxpool_stream;
  localparam int WIDTH = 8;
  localparam int LENY  = 5;
  localparam int LENP  = 2;
  localparam int LOGY  = 3;
  localparam int LOGP  = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  // Reference model state: open window contents, frame position, expected and observed results
  int win_q[$];
  int exp_q[$];
  int got_q[$];
  int fpos = 0;

  maxpool_stream_if #(.WIDTH(WIDTH)) bus ();

  maxpool_stream #(
    .WIDTH(WIDTH), .LENY(LENY), .LENP(LENP), .LOGY(LOGY), .LOGP(LOGP)
  ) dut (
    .clk(clk),
    .reset(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Pool a closed window from its rules: maximum, or floor of the mean over LENP (zero-padded)
  function automatic int pool(input int w[$]);
    int r;
    int s;
`ifdef MAXPOOL_AVG_EN
    s = 0;
    foreach (w[i]) s += w[i];
    r = s / LENP;
    if (s < 0 && r * LENP != s) r = r - 1;
`else
    r = w[0];
    foreach (w[i]) if (w[i] > r) r = w[i];
    s = 0;
`endif
    return r;
  endfunction

  // Observe transfers mid-cycle; inputs only change just after the rising edge
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.m_valid_p && bus.m_ready_p) got_q.push_back(int'(bus.m_data_out_p));
      if (bus.s_valid_y && bus.s_ready_y) begin
        win_q.push_back(int'(bus.s_data_in_y));
        if (win_q.size() == LENP || fpos == LENY - 1) begin
          exp_q.push_back(pool(win_q));
          win_q.delete();
        end
        fpos = (fpos == LENY - 1) ? 0 : fpos + 1;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    bus.s_valid_y = 1'b0;
    bus.s_data_in_y = '0;
    bus.m_ready_p = 1'b0;
    repeat (2) @(posedge clk);
    win_q.delete();
    exp_q.delete();
    got_q.delete();
    fpos = 0;
    #1 rst = 1'b0;
  endtask

  // Offer one sample and return once it has been accepted (or the wait budget expires)
  task automatic send(input int v, output int waited);
    waited = 0;
    bus.s_data_in_y = WIDTH'(v);
    bus.s_valid_y = 1'b1;
    @(negedge clk);
    while (!bus.s_ready_y && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (bus.s_ready_y !== 1'b1) begin
      failures++;
      $display("FAIL send_accept value=%0d s_ready_y=%b required 1 within 50 cycles", v, bus.s_ready_y);
    end
    @(posedge clk);
    #1 bus.s_valid_y = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.s_valid_y = 1'b1;
    bus.s_data_in_y = 8'sd33;
    bus.m_ready_p = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.s_ready_y !== 1'b0 || bus.m_valid_p !== 1'b0 || bus.m_data_out_p !== 8'sd0) begin
      failures++;
      $display("FAIL reset_state s_ready=%b m_valid=%b m_data=%0d required 0/0/0",
               bus.s_ready_y, bus.m_valid_p, bus.m_data_out_p);
    end
    do_reset();
    @(negedge clk);
    checks++;
    if (bus.s_ready_y !== 1'b1 || bus.m_valid_p !== 1'b0) begin
      failures++;
      $display("FAIL reset_release s_ready=%b m_valid=%b required 1/0", bus.s_ready_y, bus.m_valid_p);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_stream();
    int din[5] = '{3, -7, 10, 4, -2};
    bit vexp[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
`ifdef MAXPOOL_AVG_EN
    int dexp[3] = '{-2, 7, -1};
`else
    int dexp[3] = '{3, 10, -2};
`endif
    int w;
    do_reset();
    bus.m_ready_p = 1'b1;
    for (int k = 0; k < 5; k++) begin
      send(din[k], w);
      checks++;
      if (w != 0 || bus.m_valid_p !== vexp[k]) begin
        failures++;
        $display("FAIL stream_timing idx=%0d waited=%0d m_valid=%b required waited=0 m_valid=%b",
                 k, w, bus.m_valid_p, vexp[k]);
      end
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (got_q.size() != 3) begin
      failures++;
      $display("FAIL stream_count got=%0d required 3", got_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (got_q[k] != dexp[k] || exp_q[k] != dexp[k]) begin
          failures++;
          $display("FAIL stream_value idx=%0d dut=%0d model=%0d required %0d", k, got_q[k], exp_q[k], dexp[k]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int w;
`ifdef MAXPOOL_AVG_EN
    int first = 1;
    int second = 5;
`else
    int first = 2;
    int second = 6;
`endif
    do_reset();
    bus.m_ready_p = 1'b0;
    send(1, w);
    send(2, w);
    send(5, w);
    bus.s_data_in_y = 8'sd6;
    bus.s_valid_y = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus.s_ready_y !== 1'b0 || bus.m_valid_p !== 1'b1 || int'(bus.m_data_out_p) != first) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d s_ready=%b m_valid=%b m_data=%0d required 0/1/%0d",
                 c, bus.s_ready_y, bus.m_valid_p, bus.m_data_out_p, first);
      end
      @(posedge clk);
      #1;
    end
    bus.m_ready_p = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.s_ready_y !== 1'b1) begin
      failures++;
      $display("FAIL bp_release s_ready=%b required 1", bus.s_ready_y);
    end
    @(posedge clk);
    #1 bus.s_valid_y = 1'b0;
    checks++;
    if (bus.m_valid_p !== 1'b1 || int'(bus.m_data_out_p) != second) begin
      failures++;
      $display("FAIL bp_reload m_valid=%b m_data=%0d required 1/%0d", bus.m_valid_p, bus.m_data_out_p, second);
    end
    checks++;
    if (got_q.size() != 1 || got_q[0] != first) begin
      failures++;
      $display("FAIL bp_drained count=%0d required 1 with value %0d", got_q.size(), first);
    end
  endtask

  task automatic test_extremes();
    int din[6] = '{-128, -128, 127, -128, -1, -128};
`ifdef MAXPOOL_AVG_EN
    int dexp[3] = '{-128, -1, -65};
`else
    int dexp[3] = '{-128, 127, -1};
`endif
    int w;
    for (int p = 0; p < 3; p++) begin
      do_reset();
      bus.m_ready_p = 1'b1;
      send(din[2*p], w);
      send(din[2*p+1], w);
      checks++;
      if (bus.m_valid_p !== 1'b1 || int'(bus.m_data_out_p) != dexp[p] || exp_q.size() != 1 || exp_q[0] != dexp[p]) begin
        failures++;
        $display("FAIL extreme pair=%0d m_valid=%b m_data=%0d required 1/%0d", p, bus.m_valid_p, bus.m_data_out_p, dexp[p]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int din[10] = '{1, 2, 3, 4, 5, 9, 8, 7, 6, 5};
`ifdef MAXPOOL_AVG_EN
    int dexp[6] = '{1, 3, 2, 8, 6, 2};
`else
    int dexp[6] = '{2, 4, 5, 9, 7, 5};
`endif
    int w;
    int waits;
    do_reset();
    bus.m_ready_p = 1'b1;
    waits = 0;
    for (int k = 0; k < 10; k++) begin
      send(din[k], w);
      waits += w;
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (waits != 0 || got_q.size() != 6) begin
      failures++;
      $display("FAIL b2b_flow stalls=%0d outputs=%0d required 0 and 6", waits, got_q.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (got_q[k] != dexp[k] || exp_q[k] != dexp[k]) begin
          failures++;
          $display("FAIL b2b_value idx=%0d dut=%0d model=%0d required %0d", k, got_q[k], exp_q[k], dexp[k]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    int w;
`ifdef MAXPOOL_AVG_EN
    int first = 5;
`else
    int first = 6;
`endif
    do_reset();
    bus.m_ready_p = 1'b0;
    send(7, w);
    send(8, w);
    send(100, w);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (bus.m_valid_p !== 1'b0 || bus.m_data_out_p !== 8'sd0 || bus.s_ready_y !== 1'b0) begin
      failures++;
      $display("FAIL async_reset m_valid=%b m_data=%0d s_ready=%b required 0/0/0",
               bus.m_valid_p, bus.m_data_out_p, bus.s_ready_y);
    end
    win_q.delete();
    exp_q.delete();
    got_q.delete();
    fpos = 0;
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1 bus.m_ready_p = 1'b1;
    send(5, w);
    send(6, w);
    send(9, w);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (got_q.size() < 1 || got_q[0] != first) begin
      failures++;
      $display("FAIL async_first count=%0d first=%0d required %0d",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 0, first);
    end
  endtask

  task automatic test_random();
    bit took;
    bit hold;
    int held;
    int mism;
    do_reset();
    hold = 1'b0;
    held = 0;
    mism = 0;
    for (int c = 0; c < 600; c++) begin
      if (!bus.s_valid_y && $urandom_range(0, 3) != 0) begin
        bus.s_valid_y = 1'b1;
        bus.s_data_in_y = WIDTH'($urandom);
      end
      bus.m_ready_p = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (hold) begin
        checks++;
        if (bus.m_valid_p !== 1'b1 || int'(bus.m_data_out_p) != held) begin
          failures++;
          $display("FAIL rand_stable cyc=%0d m_valid=%b m_data=%0d required 1/%0d", c, bus.m_valid_p, bus.m_data_out_p, held);
        end
      end
      hold = bus.m_valid_p && !bus.m_ready_p;
      held = int'(bus.m_data_out_p);
      took = bus.s_valid_y && bus.s_ready_y;
      @(posedge clk);
      #1;
      if (took) bus.s_valid_y = 1'b0;
    end
    bus.s_valid_y = 1'b0;
    bus.m_ready_p = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (got_q.size() != exp_q.size() || got_q.size() < 20) begin
      failures++;
      $display("FAIL rand_count dut=%0d model=%0d required equal and at least 20", got_q.size(), exp_q.size());
    end else begin
      for (int k = 0; k < got_q.size(); k++) if (got_q[k] != exp_q[k]) mism++;
      checks++;
      if (mism != 0) begin
        failures++;
        $display("FAIL rand_values mismatching=%0d required 0 of %0d", mism, got_q.size());
      end
    end
  endtask

  initial begin
    bus.s_valid_y = 1'b0;
    bus.s_data_in_y = '0;
    bus.m_ready_p = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_extremes();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
